mux_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares the WIDTH-bit 2:1 mux datapath between sources X and Y.
- Drives the mux select S and registers the selected data onto a single valid/ready output stage.
- Bounds each grant to MAX_BURST beats so neither requester can starve the other.
- Sits between two producers and one downstream consumer.

---
 rtl/mux_arbiter.sv | 152 +++++++++++++++
 tb/tb_mux_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving a WIDTH-bit 2:1 mux into a single
// registered valid/ready output stage, with grants capped at MAX_BURST beats.
module mux_arbiter #(
    parameter int WIDTH     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] X,
    input  logic             X_VALID,
    output logic             X_READY,
    input  logic [WIDTH-1:0] Y,
    input  logic             Y_VALID,
    output logic             Y_READY,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             S
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_X,
        GRANT_Y
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             s_reg;
    logic [WIDTH-1:0] o_reg;
    logic             o_valid_reg;

    logic             can_load;
    logic             x_xfer;
    logic             y_xfer;
    logic             burst_end;
    logic [WIDTH-1:0] mux_data;

    // The mux is steered by the registered select, which always matches the grant.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign mux_data[gi] = s_reg ? Y[gi] : X[gi];
        end
    endgenerate

    assign can_load  = !o_valid_reg || O_READY;
    assign X_READY   = (state_reg == GRANT_X) && can_load;
    assign Y_READY   = (state_reg == GRANT_Y) && can_load;
    assign x_xfer    = X_VALID && X_READY;
    assign y_xfer    = Y_VALID && Y_READY;
    assign burst_end = (cnt_reg == LAST_BEAT);

    assign O       = o_reg;
    assign O_VALID = o_valid_reg;
    assign S       = s_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            s_reg       <= 1'b1;
            o_reg       <= '0;
            o_valid_reg <= 1'b0;
        end else begin
            if (x_xfer || y_xfer) begin
                o_reg       <= mux_data;
                o_valid_reg <= 1'b1;
            end else if (O_READY) begin
                o_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    // On a tie the side opposite the last grant wins.
                    if (X_VALID && Y_VALID) begin
                        if (s_reg) begin
                            state_reg <= GRANT_X;
                            s_reg     <= 1'b0;
                        end else begin
                            state_reg <= GRANT_Y;
                            s_reg     <= 1'b1;
                        end
                    end else if (X_VALID) begin
                        state_reg <= GRANT_X;
                        s_reg     <= 1'b0;
                    end else if (Y_VALID) begin
                        state_reg <= GRANT_Y;
                        s_reg     <= 1'b1;
                    end
                end

                GRANT_X: begin
                    if (can_load) begin
                        if (X_VALID) begin
                            if (burst_end) begin
                                cnt_reg <= '0;
                                if (Y_VALID) begin
                                    state_reg <= GRANT_Y;
                                    s_reg     <= 1'b1;
                                end
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end else begin
                            cnt_reg <= '0;
                            if (Y_VALID) begin
                                state_reg <= GRANT_Y;
                                s_reg     <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                end

                GRANT_Y: begin
                    if (can_load) begin
                        if (Y_VALID) begin
                            if (burst_end) begin
                                cnt_reg <= '0;
                                if (X_VALID) begin
                                    state_reg <= GRANT_X;
                                    s_reg     <= 1'b0;
                                end
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end else begin
                            cnt_reg <= '0;
                            if (X_VALID) begin
                                state_reg <= GRANT_X;
                                s_reg     <= 1'b0;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: stimulus queues expected O beats, a monitor
// pops and compares them on every O handshake.
module tb_mux_arbiter;

    localparam int WIDTH     = 2;
    localparam int MAX_BURST = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] X;
    logic             X_VALID;
    logic             X_READY;
    logic [WIDTH-1:0] Y;
    logic             Y_VALID;
    logic             Y_READY;
    logic [WIDTH-1:0] O;
    logic             O_VALID;
    logic             O_READY;
    logic             S;

    mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .X       (X),
        .X_VALID (X_VALID),
        .X_READY (X_READY),
        .Y       (Y),
        .Y_VALID (Y_VALID),
        .Y_READY (Y_READY),
        .O       (O),
        .O_VALID (O_VALID),
        .O_READY (O_READY),
        .S       (S)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] xdat[16];
    logic [WIDTH-1:0] ydat[16];
    bit               xen[64];
    bit               yen[64];
    bit               rdy[64];
    bit               s_log[64];
    bit               xr_log[64];
    bit               yr_log[64];
    bit               ov_log[64];
    logic [WIDTH-1:0] o_log[64];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push(input int v);
        exp_q.push_back(WIDTH'(v));
    endtask

    task automatic default_pattern();
        for (int c = 0; c < 64; c++) begin
            xen[c] = 1'b1;
            yen[c] = 1'b1;
            rdy[c] = 1'b1;
        end
    endtask

    // Cycle-by-cycle producers: each side advances to its next beat after a handshake.
    task automatic run(input int xn, input int yn, input int cycles);
        int xi = 0;
        int yi = 0;
        bit xt = 1'b0;
        bit yt = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            if (xt) xi++;
            if (yt) yi++;
            X_VALID = xen[c] && (xi < xn);
            X       = (xi < xn) ? xdat[xi] : '0;
            Y_VALID = yen[c] && (yi < yn);
            Y       = (yi < yn) ? ydat[yi] : '0;
            O_READY = rdy[c];
            #1;
            xt        = X_VALID && X_READY;
            yt        = Y_VALID && Y_READY;
            s_log[c]  = S;
            xr_log[c] = X_READY;
            yr_log[c] = Y_READY;
            ov_log[c] = O_VALID;
            o_log[c]  = O;
            chk("ready_exclusive", int'(X_READY && Y_READY), 0);
        end
        chk("x_beats_sent", xi + int'(xt), xn);
        chk("y_beats_sent", yi + int'(yt), yn);
    endtask

    // Monitor: compares every O handshake against the scoreboard and checks O holds while stalled.
    initial begin
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] held_o;
        bit               held_chk;
        held_chk = 1'b0;
        held_o   = '0;
        forever begin
            @(negedge CLK);
            #2;
            if (RST) begin
                held_chk = 1'b0;
            end else begin
                if (held_chk) begin
                    checks++;
                    if (!O_VALID || O !== held_o) begin
                        errors++;
                        $display("FAIL o_hold: got valid=%0d data=%0d expected valid=1 data=%0d",
                                 O_VALID, O, held_o);
                    end
                end
                held_chk = O_VALID && !O_READY;
                held_o   = O;
                if (O_VALID && O_READY) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL o_unexpected: got data=%0d expected no beat", O);
                    end else begin
                        e = exp_q.pop_front();
                        if (O !== e) begin
                            errors++;
                            $display("FAIL o_data: got %0d expected %0d", O, e);
                        end else begin
                            $display("beat O=%0d S=%0d", O, S);
                        end
                    end
                end
            end
        end
    end

    initial begin
        RST     = 1'b1;
        X       = '0;
        Y       = '0;
        X_VALID = 1'b0;
        Y_VALID = 1'b0;
        O_READY = 1'b0;

        // Reset values before any clock edge.
        #2;
        chk("rst_o_valid", int'(O_VALID), 0);
        chk("rst_o", int'(O), 0);
        chk("rst_x_ready", int'(X_READY), 0);
        chk("rst_y_ready", int'(Y_READY), 0);
        chk("rst_s", int'(S), 1);
        @(negedge CLK);
        RST = 1'b0;

        // X only, burst continues past MAX_BURST while Y idles.
        default_pattern();
        for (int i = 0; i < 6; i++) xdat[i] = WIDTH'(i % 4);
        push(0); push(1); push(2); push(3); push(0); push(1);
        run(6, 0, 10);
        chk("x_only_ready_c0", int'(xr_log[0]), 0);
        chk("x_only_s_c1", int'(s_log[1]), 0);
        chk("x_only_ready_c1", int'(xr_log[1]), 1);
        chk("x_only_ov_c1", int'(ov_log[1]), 0);
        for (int c = 2; c <= 7; c++) chk("x_only_ov_nogap", int'(ov_log[c]), 1);
        chk("x_only_ov_c8", int'(ov_log[8]), 0);

        // Tie from idle with S=0 goes to Y, then 4/4 alternation without bubbles.
        default_pattern();
        for (int i = 0; i < 12; i++) begin
            xdat[i] = WIDTH'(i % 4);
            ydat[i] = WIDTH'(3 - (i % 4));
        end
        for (int r = 0; r < 3; r++) begin
            push(3); push(2); push(1); push(0);
            push(0); push(1); push(2); push(3);
        end
        run(12, 12, 28);
        chk("tie_s_c0", int'(s_log[0]), 0);
        chk("tie_s_c1", int'(s_log[1]), 1);
        chk("tie_y_ready_c1", int'(yr_log[1]), 1);
        chk("tie_x_ready_c1", int'(xr_log[1]), 0);
        chk("both_s_c4", int'(s_log[4]), 1);
        chk("both_s_c5", int'(s_log[5]), 0);
        chk("both_s_c8", int'(s_log[8]), 0);
        chk("both_s_c9", int'(s_log[9]), 1);
        for (int c = 2; c <= 25; c++) chk("both_ov_nogap", int'(ov_log[c]), 1);
        chk("both_ov_c26", int'(ov_log[26]), 0);

        // Backpressure after 2 X beats; burst resumes for exactly 2 more beats.
        default_pattern();
        yen[0] = 1'b0;
        rdy[3] = 1'b0; rdy[4] = 1'b0; rdy[5] = 1'b0;
        xdat[0] = 2; xdat[1] = 3; xdat[2] = 1; xdat[3] = 0; xdat[4] = 3; xdat[5] = 1;
        ydat[0] = 1; ydat[1] = 0; ydat[2] = 3; ydat[3] = 2;
        push(2); push(3); push(1); push(0);
        push(1); push(0); push(3); push(2);
        push(3); push(1);
        run(6, 4, 16);
        for (int c = 3; c <= 5; c++) begin
            chk("bp_x_ready", int'(xr_log[c]), 0);
            chk("bp_o_valid", int'(ov_log[c]), 1);
            chk("bp_o_held", int'(o_log[c]), 3);
        end
        chk("bp_x_ready_c6", int'(xr_log[6]), 1);
        chk("bp_s_c7", int'(s_log[7]), 0);
        chk("bp_s_c8", int'(s_log[8]), 1);
        chk("bp_y_ready_c8", int'(yr_log[8]), 1);
        chk("bp_s_c11", int'(s_log[11]), 1);
        chk("bp_s_c12", int'(s_log[12]), 0);

        // Early release: X drops after 2 beats, Y takes over and gets a full burst.
        default_pattern();
        yen[0] = 1'b0;
        xen[3] = 1'b0;
        xdat[0] = 1; xdat[1] = 3; xdat[2] = 0; xdat[3] = 2;
        ydat[0] = 2; ydat[1] = 1; ydat[2] = 3; ydat[3] = 0;
        push(1); push(3); push(2); push(1); push(3); push(0); push(0); push(2);
        run(4, 4, 12);
        chk("er_s_c3", int'(s_log[3]), 0);
        chk("er_s_c4", int'(s_log[4]), 1);
        chk("er_y_ready_c4", int'(yr_log[4]), 1);
        chk("er_s_c7", int'(s_log[7]), 1);
        chk("er_s_c8", int'(s_log[8]), 0);
        chk("er_x_ready_c8", int'(xr_log[8]), 1);

        // Reset while a beat is stalled in O: the beat is discarded.
        default_pattern();
        for (int c = 0; c < 64; c++) rdy[c] = 1'b0;
        xdat[0] = 2;
        run(1, 0, 3);
        chk("mid_ov_before", int'(ov_log[2]), 1);
        chk("mid_o_before", int'(o_log[2]), 2);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_o_valid", int'(O_VALID), 0);
        chk("mid_rst_o", int'(O), 0);
        chk("mid_rst_x_ready", int'(X_READY), 0);
        chk("mid_rst_y_ready", int'(Y_READY), 0);
        chk("mid_rst_s", int'(S), 1);
        #1;
        RST     = 1'b0;
        X_VALID = 1'b0;

        // After release the arbiter starts from IDLE.
        default_pattern();
        ydat[0] = 1; ydat[1] = 2;
        push(1); push(2);
        run(0, 2, 5);
        chk("post_y_ready_c0", int'(yr_log[0]), 0);
        chk("post_x_ready_c0", int'(xr_log[0]), 0);
        chk("post_y_ready_c1", int'(yr_log[1]), 1);
        chk("post_s_c1", int'(s_log[1]), 1);

        X_VALID = 1'b0;
        Y_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
